// File: rtl/word_flag_unit_pkg.sv
// ---------------------------------------------------------------------------
// word_flag_unit_pkg
// Shared types and constants for the byte-serial ALU status stage.
//   BYTE_W  : datapath byte width
//   state_e : controller states (ACCUM collects bytes, DONE holds a result)
//   flags_t : registered status flag bundle presented downstream
// ---------------------------------------------------------------------------
package word_flag_unit_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  typedef struct packed {
    logic zr;  // whole word is zero
    logic ng;  // word MSB
  } flags_t;

endpackage : word_flag_unit_pkg

// File: rtl/word_flag_unit_or8way.sv
// ---------------------------------------------------------------------------
// or8way
// Eight-input OR reduction: flags whether any bit of a byte is set.
// Ports:
//   byte_i : input byte
//   any_c  : combinational OR of all bits of byte_i
// ---------------------------------------------------------------------------
module or8way
  import word_flag_unit_pkg::*;
(
  input  logic [BYTE_W-1:0] byte_i,
  output logic              any_c
);

  assign any_c = |byte_i;

endmodule : or8way

// File: rtl/word_flag_unit.sv
// ---------------------------------------------------------------------------
// word_flag_unit
// Byte-serial ALU status stage. Collects the NBYTES bytes of a word (LSB
// byte first) over a valid/ready stream, reduces each byte to a nonzero bit,
// and presents registered zero/negative flags plus the per-byte nonzero mask
// over a second valid/ready handshake. Input and output do not overlap, so a
// word costs NBYTES+1 cycles at full rate.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   in_valid   : in_byte carries a valid byte
//   in_ready   : byte is accepted this cycle (combinational)
//   in_byte    : data byte, byte 0 first
//   abort      : discard any partially collected word (ignored in DONE)
//   out_valid  : zr/ng/nz_mask carry a completed word's flags
//   out_ready  : downstream accepts the flags
//   zr         : every bit of the word is zero
//   ng         : bit 7 of the final byte
//   nz_mask    : bit i is the OR of all bits of byte i
// ---------------------------------------------------------------------------
module word_flag_unit
  import word_flag_unit_pkg::*;
#(
  parameter int unsigned NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BYTE_W-1:0]   in_byte,
  input  logic                abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                zr,
  output logic                ng,
  output logic [NBYTES-1:0]   nz_mask
);

  localparam int unsigned CNT_W = $clog2(NBYTES + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NBYTES-1:0]   nz_acc_q, nz_acc_d;
  logic                out_valid_q, out_valid_d;
  flags_t              flags_q, flags_d;
  logic [NBYTES-1:0]   nz_mask_q, nz_mask_d;

  logic                byte_nz_c;
  logic                in_ready_c;
  logic                last_byte_c;
  logic [NBYTES-1:0]   acc_new_c;

  // Per-byte any-bit-set reduction of the incoming byte.
  or8way u_or8way (
    .byte_i (in_byte),
    .any_c  (byte_nz_c)
  );

  assign last_byte_c = (cnt_q == CNT_W'(NBYTES - 1));

  // Accumulator with the current byte's nonzero bit merged at position cnt_q.
  always_comb begin
    acc_new_c = nz_acc_q;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (cnt_q == CNT_W'(i)) begin
        acc_new_c[i] = byte_nz_c;
      end
    end
  end

  // Next-state, counter, accumulator and output-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nz_acc_d    = nz_acc_q;
    out_valid_d = out_valid_q;
    flags_d     = flags_q;
    nz_mask_d   = nz_mask_q;
    in_ready_c  = 1'b0;

    case (state_q)
      ACCUM: begin
        // abort masks ready so a byte presented alongside it is never taken.
        in_ready_c = ~abort;
        if (abort) begin
          cnt_d    = '0;
          nz_acc_d = '0;
        end else if (in_valid) begin
          if (last_byte_c) begin
            flags_d.zr  = ~|acc_new_c;
            flags_d.ng  = in_byte[BYTE_W-1];
            nz_mask_d   = acc_new_c;
            out_valid_d = 1'b1;
            state_d     = DONE;
            cnt_d       = '0;
            nz_acc_d    = '0;
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
            nz_acc_d = acc_new_c;
          end
        end
      end

      DONE: begin
        // Result is held until consumed; abort has no effect here.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      nz_acc_q    <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
      nz_mask_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nz_acc_q    <= nz_acc_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
      nz_mask_q   <= nz_mask_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign zr        = flags_q.zr;
  assign ng        = flags_q.ng;
  assign nz_mask   = nz_mask_q;

endmodule : word_flag_unit

// File: tb/tb_word_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_word_flag_unit
// Directed self-checking bench for word_flag_unit with NBYTES=2.
// ---------------------------------------------------------------------------
module tb_word_flag_unit;

  localparam int unsigned NB = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_byte;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic          zr;
  logic          ng;
  logic [NB-1:0] nz_mask;

  int checks = 0;
  int errors = 0;

  word_flag_unit #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .zr        (zr),
    .ng        (ng),
    .nz_mask   (nz_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", 8'(in_ready), 8'h1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic ezr, input logic eng,
                            input logic [NB-1:0] emask);
    chk({tag, "_valid"}, 8'(out_valid), 8'h1);
    chk({tag, "_zr"},    8'(zr),        8'(ezr));
    chk({tag, "_ng"},    8'(ng),        8'(eng));
    chk({tag, "_mask"},  8'(nz_mask),   8'(emask));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    abort     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_valid", 8'(out_valid), 8'h0);
    chk("rst_zr",    8'(zr),        8'h0);
    chk("rst_ng",    8'(ng),        8'h0);
    chk("rst_mask",  8'(nz_mask),   8'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 8'(in_ready), 8'h1);

    // Zero word
    send_byte(8'h00);
    send_byte(8'h00);
    chk_result("zero", 1'b1, 1'b0, 2'b00);
    chk("zero_ready_done", 8'(in_ready), 8'h0);
    tick();
    chk("zero_valid_clr", 8'(out_valid), 8'h0);

    // Negative, nonzero word then positive word
    send_byte(8'h01);
    send_byte(8'h80);
    chk_result("neg", 1'b0, 1'b1, 2'b11);
    tick();
    send_byte(8'h00);
    send_byte(8'h7F);
    chk_result("pos", 1'b0, 1'b0, 2'b10);
    tick();

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    send_byte(8'h00);
    send_byte(8'h04);
    chk_result("bp", 1'b0, 1'b0, 2'b10);
    in_valid = 1'b1;
    in_byte  = 8'h10;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready",    8'(in_ready),  8'h0);
      chk("bp_valid",    8'(out_valid), 8'h1);
      chk("bp_zr_hold",  8'(zr),        8'h0);
      chk("bp_mask_hold", 8'(nz_mask),  8'h2);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 8'(out_valid), 8'h0);
    chk("bp_release_ready", 8'(in_ready),  8'h1);
    tick();
    in_valid = 1'b0;
    send_byte(8'h00);
    chk_result("bp_next", 1'b0, 1'b0, 2'b01);
    tick();

    // Abort discards the partial word and refuses the concurrent byte
    send_byte(8'hFF);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    #1;
    chk("abort_ready", 8'(in_ready), 8'h0);
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    send_byte(8'h00);
    send_byte(8'h00);
    chk_result("abort", 1'b1, 1'b0, 2'b00);
    tick();

    // Async reset mid-word
    send_byte(8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mid_zr",   8'(zr),      8'h0);
    chk("arst_mid_mask", 8'(nz_mask), 8'h0);
    #2;
    rst_n = 1'b1;
    tick();
    send_byte(8'h00);
    send_byte(8'h00);
    chk_result("arst_mid_next", 1'b1, 1'b0, 2'b00);
    tick();

    // Async reset while holding a result in DONE
    out_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h80);
    chk_result("arst_done_pre", 1'b0, 1'b1, 2'b11);
    #2;
    rst_n = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_done_valid", 8'(out_valid), 8'h0);
    chk("arst_done_zr",    8'(zr),        8'h0);
    chk("arst_done_ng",    8'(ng),        8'h0);
    chk("arst_done_mask",  8'(nz_mask),   8'h0);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    send_byte(8'h00);
    send_byte(8'h00);
    chk_result("arst_done_next", 1'b1, 1'b0, 2'b00);
    tick();

    // Idle gap mid-word: count holds, exactly one result
    send_byte(8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    chk("gap_no_result", 8'(out_valid), 8'h0);
    send_byte(8'h01);
    chk_result("gap", 1'b0, 1'b0, 2'b10);
    tick();
    chk("gap_single_a", 8'(out_valid), 8'h0);
    tick();
    chk("gap_single_b", 8'(out_valid), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_word_flag_unit
